ddr3_odt_dly_ctrl: RTL

//  Sequencer for the dynamic TX delay line of the DDR3 ODT output IOD lane.

---
 rtl/ddr3_dly_pkg.sv | 23 ++
 rtl/ddr3_dly_gap_cnt.sv | 34 +++
 rtl/ddr3_odt_dly_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ddr3_dly_pkg.sv
// Shared definitions for the DDR3 ODT IOD delay-line sequencer.
// Contents: tap width, gap-counter width, direction encodings and the
// sequencer state type.
package ddr3_dly_pkg;

  localparam int unsigned TAP_W = 8;
  localparam int unsigned GAP_W = 4;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  typedef enum logic [2:0] {
    ST_INIT_LOAD,
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_WAIT,
    ST_SETUP,
    ST_MOVE,
    ST_GAP,
    ST_FIN
  } dly_state_t;

endpackage

// File: rtl/ddr3_dly_gap_cnt.sv
// Idle-gap down-counter used to space delay-line pulses.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous reset, active-high (count -> 0)
//   load     in  load load_val (has priority over dec)
//   dec      in  decrement, saturating at zero
//   load_val in  GAP_W-bit reload value
//   zero     out count is zero
module ddr3_dly_gap_cnt
  import ddr3_dly_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [GAP_W-1:0] load_val,
  output logic             zero
);

  logic [GAP_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ddr3_odt_dly_ctrl.sv
// Sequencer for the dynamic TX delay line of the DDR3 ODT output IOD lane.
// Converts "go to tap N" and "reload" requests into spaced LOAD / MOVE /
// DIRECTION pulses, tracks the current tap and stops on OUT_OF_RANGE.
// Ports:
//   FAB_CLK                 in  fabric clock
//   SYNC_RST                in  synchronous reset, active-high
//   LOAD_REQ                in  reload delay line to INIT_TAP
//   REQ_VALID / REQ_READY   in/out tap request handshake
//   REQ_TAP                 in  target tap
//   BUSY, DONE, ERR         out sequence status (ERR sticky)
//   CUR_TAP                 out tap currently held by the delay line
//   DELAY_LINE_MOVE/DIRECTION/LOAD out to IOD
//   DELAY_LINE_OUT_OF_RANGE in  from IOD
module ddr3_odt_dly_ctrl
  import ddr3_dly_pkg::*;
#(
  parameter logic [TAP_W-1:0] INIT_TAP = 8'd1,
  parameter logic [TAP_W-1:0] MAX_TAP  = 8'd127,
  parameter int unsigned      MOVE_GAP = 4,
  parameter int unsigned      LOAD_GAP = 4
) (
  input  logic             FAB_CLK,
  input  logic             SYNC_RST,
  input  logic             LOAD_REQ,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [TAP_W-1:0] REQ_TAP,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] CUR_TAP,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  input  logic             DELAY_LINE_OUT_OF_RANGE
);

  // Counter is reloaded with GAP-1 so the zero flag marks the last gap cycle.
  localparam logic [GAP_W-1:0] MOVE_RELOAD = GAP_W'(MOVE_GAP - 1);
  localparam logic [GAP_W-1:0] LOAD_RELOAD = GAP_W'(LOAD_GAP - 1);

  dly_state_t       state;
  logic             rst_q;     // high for the cycle(s) after a reset edge
  logic [TAP_W-1:0] target;
  logic             dir_q;
  logic             err_q;
  logic             cnt_load;
  logic             cnt_dec;
  logic [GAP_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             active;

  ddr3_dly_gap_cnt u_gap_cnt (
    .clk      (FAB_CLK),
    .rst      (SYNC_RST),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_INIT_LOAD: begin
        if (!rst_q) begin
          cnt_load = 1'b1;
          cnt_val  = LOAD_RELOAD;
        end
      end
      ST_LOAD: begin
        cnt_load = 1'b1;
        cnt_val  = LOAD_RELOAD;
      end
      ST_MOVE: begin
        cnt_load = 1'b1;
        cnt_val  = MOVE_RELOAD;
      end
      ST_LOAD_WAIT, ST_GAP: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state   <= ST_INIT_LOAD;
      rst_q   <= 1'b1;
      CUR_TAP <= INIT_TAP;
      target  <= INIT_TAP;
      dir_q   <= DIR_DEC;
      err_q   <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      case (state)
        // Held here while rst_q is still set so the LOAD pulse lands on the
        // first cycle with outputs enabled.
        ST_INIT_LOAD: if (!rst_q) state <= ST_LOAD_WAIT;
        ST_IDLE: begin
          if (LOAD_REQ) begin
            state <= ST_LOAD;
          end else if (REQ_VALID) begin
            target <= REQ_TAP;
            dir_q  <= (REQ_TAP > CUR_TAP) ? DIR_INC : DIR_DEC;
            err_q  <= (REQ_TAP > MAX_TAP);
            if ((REQ_TAP > MAX_TAP) || (REQ_TAP == CUR_TAP)) begin
              state <= ST_FIN;
            end else begin
              state <= ST_SETUP;
            end
          end
        end
        ST_LOAD: begin
          CUR_TAP <= INIT_TAP;
          err_q   <= 1'b0;
          state   <= ST_LOAD_WAIT;
        end
        ST_LOAD_WAIT: if (cnt_zero) state <= ST_FIN;
        ST_SETUP:     state <= ST_MOVE;
        ST_MOVE: begin
          CUR_TAP <= (dir_q == DIR_INC) ? CUR_TAP + 1'b1 : CUR_TAP - 1'b1;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt_zero) begin
            if (DELAY_LINE_OUT_OF_RANGE) begin
              // The IOD refused the last step: undo it.
              CUR_TAP <= (dir_q == DIR_INC) ? CUR_TAP - 1'b1 : CUR_TAP + 1'b1;
              err_q   <= 1'b1;
              state   <= ST_FIN;
            end else if (CUR_TAP == target) begin
              state <= ST_FIN;
            end else begin
              state <= ST_MOVE;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_INIT_LOAD;
      endcase
    end
  end

  // All status/strobe outputs are forced low for the cycle following a reset edge.
  assign active               = ~rst_q;
  assign REQ_READY            = active & (state == ST_IDLE);
  assign BUSY                 = active & (state != ST_IDLE);
  assign DONE                 = active & (state == ST_FIN);
  assign ERR                  = active & err_q;
  assign DELAY_LINE_MOVE      = active & (state == ST_MOVE);
  assign DELAY_LINE_LOAD      = active & ((state == ST_INIT_LOAD) | (state == ST_LOAD));
  assign DELAY_LINE_DIRECTION = active & dir_q;

endmodule
